av_st_pkt_arbiter: RTL and testbench
====================================

// Module: av_st_pkt_arbiter
// PURPOSE
//  Packet-atomic round-robin arbiter: merges NUM_PORTS Avalon-ST sources (pkt_replay_avalon_st or
//  upstream FIFOs) onto one Avalon-ST sink (FIFO or pkt_writer_avalon_st). Grant held from SOP to
//  EOP; m_av_channel tags source index. One registered output stage; 1-cycle arbitration bubble/pkt.
// PARAMETERS
//  NUM_PORTS    2            number of source ports (2..8)
//  TDATA_WIDTH  512          data bus width, bits
//  EMPTY_WIDTH  TDATA_WIDTH/8 av_empty width (codebase bus convention)
//  CH_WIDTH     (NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1)  channel tag width
// PORTS
//  clk                 in   1                      core clock
//  rst                 in   1                      async reset, active-high
//  s_av_data           in   [NUM_PORTS][TDATA_WIDTH] per-source data
//  s_av_empty          in   [NUM_PORTS][EMPTY_WIDTH] per-source empty
//  s_av_valid          in   [NUM_PORTS]            per-source valid
//  s_av_startofpacket  in   [NUM_PORTS]            per-source SOP
//  s_av_endofpacket    in   [NUM_PORTS]            per-source EOP
//  s_av_error          in   [NUM_PORTS]            per-source error
//  s_av_ready          out  [NUM_PORTS]            per-source ready
//  m_av_data/empty     out  TDATA_WIDTH/EMPTY_WIDTH merged beat
//  m_av_valid/startofpacket/endofpacket/error  out 1 each
//  m_av_channel        out  CH_WIDTH               index of granted source
//  m_av_ready          in   1                      sink ready
//  pkt_cnt             out  32                     packets forwarded (EOP accepted at m side)
//  sop_err             out  1                      1-cycle pulse: first beat of grant lacked SOP
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, rr_ptr=NUM_PORTS-1, grant=0, all s_av_ready=0, m_av_valid=0,
//    m_av_sop/eop/error=0, m_av_data/empty/channel=0, pkt_cnt=0, sop_err=0. Reset mid-packet drops
//    the in-flight packet; no recovery beats emitted.
//  - Output stage: load = !m_av_valid || m_av_ready. s_av_ready[i] = (state==BUSY) && grant==i && load.
//    Beat accepted on s side (valid&&ready) registers into m_* next edge; m_av_valid held until
//    m_av_ready. Full throughput (1 beat/cycle) inside a packet.
//  - FSM IDLE: if any s_av_valid, winner = first set index searching rr_ptr+1, rr_ptr+2, ... (mod
//    NUM_PORTS); grant<=winner, state<=BUSY. No beat accepted in IDLE (1-cycle bubble).
//  - FSM BUSY: forward granted port only; m_av_channel<=grant. On accepted beat with EOP: state<=IDLE,
//    rr_ptr<=grant. Beat with SOP and EOP (single-beat pkt) handled identically.
//  - sop_err pulses in the cycle after accepting the first beat of a grant whose SOP=0; beat still
//    forwarded unchanged. SOP mid-packet ignored for arbitration (grant kept until EOP).
//  - Non-granted sources stall (ready=0); valid deassert by granted source mid-packet keeps grant.
//  - pkt_cnt increments when m_av_valid&&m_av_ready&&m_av_endofpacket; wraps 2^32-1 -> 0.
//  - Simultaneous requests: strict rotation; port just served is lowest priority next round.
// STRUCTURE
//  - Package av_st_pkg: typedef av_beat_t {data, empty, sop, eop, error}, parameterised widths via
//    localparams TDATA_WIDTH=512, EMPTY_WIDTH; enum arb_state_e {IDLE, BUSY}.
//  - Sub-module rr_picker (combinational: req vector + ptr -> onehot/index, found flag), reusable.
//  - Top: FSM, grant reg, output register stage, counters.
// TESTING
//  1 Reset: rst=1 30 cycles, all s_av_valid=1 -> all s_av_ready=0, m_av_valid=0, pkt_cnt=0.
//  2 Round robin: ports 0,1 each present 3x 2-beat pkts continuously, m_av_ready=1 -> m_av_channel
//    order 0,1,0,1,0,1, never interleaved within pkt; pkt_cnt=6; 1 bubble cycle between pkts.
//  3 Backpressure: 5-beat pkt on port 1, m_av_ready toggles 1010... -> 5 beats out in order, data
//    unchanged, no drop/duplicate, s_av_ready[1]=0 whenever m_av_valid&&!m_av_ready.
//  4 Source gap: port 0 drops valid 3 cycles mid-pkt while port 1 requests -> grant stays 0 until
//    EOP; port 1 pkt follows.
//  5 Missing SOP: port 0 first beat SOP=0 -> beat forwarded, sop_err pulses once; single-beat pkt
//    (SOP=EOP=1, empty=0x3C) -> forwarded with empty intact, pkt_cnt+1.
//  6 Async reset mid-pkt: rst asserted between clk edges at beat 2 of 4 -> m_av_valid=0 immediately,
//    state IDLE after release; next pkt from rr_ptr reset order (port 0 first).

Source files
------------

// File: rtl/av_st_pkg.sv
// Shared Avalon-ST definitions for the packet arbiter slice.
//  - TDATA_WIDTH / EMPTY_WIDTH : default bus widths (empty is one bit per data byte)
//  - av_beat_t                 : one Avalon-ST beat at the default widths
//  - arb_state_e               : arbiter FSM states
package av_st_pkg;

  localparam int TDATA_WIDTH = 512;
  localparam int EMPTY_WIDTH = TDATA_WIDTH / 8;

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [EMPTY_WIDTH-1:0] empty;
    logic                   sop;
    logic                   eop;
    logic                   error;
  } av_beat_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

endpackage

// File: rtl/av_st_pkt_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//  req        in  [N]   request vector
//  ptr        in  [IW]  index served last; the search starts at ptr+1 (mod N)
//  gnt_onehot out [N]   one-hot winner (all zero when nothing requests)
//  gnt_idx    out [IW]  binary winner index (0 when nothing requests)
//  found      out 1     at least one request present
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          found
);

  int unsigned idx;

  // Candidates are visited from lowest priority (ptr itself) up to highest
  // (ptr+1), so the nearest requester after ptr is the last one written.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + N - k) % N;
      if (req[idx]) begin
        gnt_onehot      = '0;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IW'(idx);
        found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/av_st_pkt_arbiter.sv
// av_st_pkt_arbiter: packet-atomic round-robin merge of NUM_PORTS Avalon-ST
// sources onto one Avalon-ST sink. A grant is held from the first beat to EOP;
// one idle arbitration cycle separates packets. Single registered output stage.
//  clk, rst            clock, asynchronous active-high reset
//  s_av_*              per-source beat inputs, s_av_ready per-source outputs
//  m_av_*              merged beat outputs, m_av_channel = granted source index
//  m_av_ready          sink ready
//  pkt_cnt             packets delivered (EOP handshakes on the m side), wraps
//  sop_err             1-cycle pulse: first beat of a grant had SOP=0
module av_st_pkt_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int TDATA_WIDTH = 512,
  parameter int EMPTY_WIDTH = TDATA_WIDTH / 8,
  parameter int CH_WIDTH    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0][TDATA_WIDTH-1:0] s_av_data,
  input  logic [NUM_PORTS-1:0][EMPTY_WIDTH-1:0] s_av_empty,
  input  logic [NUM_PORTS-1:0]                  s_av_valid,
  input  logic [NUM_PORTS-1:0]                  s_av_startofpacket,
  input  logic [NUM_PORTS-1:0]                  s_av_endofpacket,
  input  logic [NUM_PORTS-1:0]                  s_av_error,
  output logic [NUM_PORTS-1:0]                  s_av_ready,
  output logic [TDATA_WIDTH-1:0]                m_av_data,
  output logic [EMPTY_WIDTH-1:0]                m_av_empty,
  output logic                                  m_av_valid,
  output logic                                  m_av_startofpacket,
  output logic                                  m_av_endofpacket,
  output logic                                  m_av_error,
  output logic [CH_WIDTH-1:0]                   m_av_channel,
  input  logic                                  m_av_ready,
  output logic [31:0]                           pkt_cnt,
  output logic                                  sop_err
);

  import av_st_pkg::*;

  arb_state_e                 state_q, state_d;
  logic [CH_WIDTH-1:0]        grant_q, grant_d;
  logic [NUM_PORTS-1:0]       grant_oh_q, grant_oh_d;
  logic [CH_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
  logic                       first_beat_q, first_beat_d;

  logic [TDATA_WIDTH-1:0]     m_data_q, m_data_d;
  logic [EMPTY_WIDTH-1:0]     m_empty_q, m_empty_d;
  logic                       m_valid_q, m_valid_d;
  logic                       m_sop_q, m_sop_d;
  logic                       m_eop_q, m_eop_d;
  logic                       m_error_q, m_error_d;
  logic [CH_WIDTH-1:0]        m_channel_q, m_channel_d;
  logic [31:0]                pkt_cnt_q, pkt_cnt_d;
  logic                       sop_err_q, sop_err_d;

  logic                       load;
  logic                       accept;
  logic [NUM_PORTS-1:0]       pick_onehot;
  logic [CH_WIDTH-1:0]        pick_idx;
  logic                       pick_found;

  rr_picker #(
    .N  (NUM_PORTS),
    .IW (CH_WIDTH)
  ) u_rr_picker (
    .req        (s_av_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .found      (pick_found)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign load       = !m_valid_q || m_av_ready;
  assign s_av_ready = (state_q == BUSY && load) ? grant_oh_q : '0;
  assign accept     = (state_q == BUSY) && load && s_av_valid[grant_q];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    rr_ptr_d     = rr_ptr_q;
    first_beat_d = first_beat_q;
    m_data_d     = m_data_q;
    m_empty_d    = m_empty_q;
    m_valid_d    = m_valid_q;
    m_sop_d      = m_sop_q;
    m_eop_d      = m_eop_q;
    m_error_d    = m_error_q;
    m_channel_d  = m_channel_q;
    pkt_cnt_d    = pkt_cnt_q;
    sop_err_d    = 1'b0;

    if (m_valid_q && m_av_ready && m_eop_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    if (load) begin
      m_valid_d = accept;
    end

    if (accept) begin
      m_data_d    = s_av_data[grant_q];
      m_empty_d   = s_av_empty[grant_q];
      m_sop_d     = s_av_startofpacket[grant_q];
      m_eop_d     = s_av_endofpacket[grant_q];
      m_error_d   = s_av_error[grant_q];
      m_channel_d = grant_q;
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick_idx;
          grant_oh_d   = pick_onehot;
          first_beat_d = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          first_beat_d = 1'b0;
          sop_err_d    = first_beat_q && !s_av_startofpacket[grant_q];
          if (s_av_endofpacket[grant_q]) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      rr_ptr_q     <= CH_WIDTH'(NUM_PORTS - 1);
      first_beat_q <= 1'b0;
      m_data_q     <= '0;
      m_empty_q    <= '0;
      m_valid_q    <= 1'b0;
      m_sop_q      <= 1'b0;
      m_eop_q      <= 1'b0;
      m_error_q    <= 1'b0;
      m_channel_q  <= '0;
      pkt_cnt_q    <= '0;
      sop_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      rr_ptr_q     <= rr_ptr_d;
      first_beat_q <= first_beat_d;
      m_data_q     <= m_data_d;
      m_empty_q    <= m_empty_d;
      m_valid_q    <= m_valid_d;
      m_sop_q      <= m_sop_d;
      m_eop_q      <= m_eop_d;
      m_error_q    <= m_error_d;
      m_channel_q  <= m_channel_d;
      pkt_cnt_q    <= pkt_cnt_d;
      sop_err_q    <= sop_err_d;
    end
  end

  assign m_av_data          = m_data_q;
  assign m_av_empty         = m_empty_q;
  assign m_av_valid         = m_valid_q;
  assign m_av_startofpacket = m_sop_q;
  assign m_av_endofpacket   = m_eop_q;
  assign m_av_error         = m_error_q;
  assign m_av_channel       = m_channel_q;
  assign pkt_cnt            = pkt_cnt_q;
  assign sop_err            = sop_err_q;

endmodule

// File: tb/tb_av_st_pkt_arbiter.sv
// Bench for av_st_pkt_arbiter: directed scenarios plus a randomized phase,
// checked against a packet-level reference model of the arbitration rules.
module tb_av_st_pkt_arbiter;
  import av_st_pkg::*;

  localparam int NP = 2;
  localparam int DW = av_st_pkg::TDATA_WIDTH;
  localparam int EW = av_st_pkg::EMPTY_WIDTH;
  localparam int CW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0][DW-1:0] s_data;
  logic [NP-1:0][EW-1:0] s_empty;
  logic [NP-1:0]         s_valid, s_sop, s_eop, s_err, s_ready;
  logic [DW-1:0]         m_data;
  logic [EW-1:0]         m_empty;
  logic                  m_valid, m_sop, m_eop, m_err, m_ready;
  logic [CW-1:0]         m_ch;
  logic [31:0]           pkt_cnt;
  logic                  sop_err;

  av_st_pkt_arbiter #(
    .NUM_PORTS   (NP),
    .TDATA_WIDTH (DW),
    .EMPTY_WIDTH (EW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_av_data          (s_data),
    .s_av_empty         (s_empty),
    .s_av_valid         (s_valid),
    .s_av_startofpacket (s_sop),
    .s_av_endofpacket   (s_eop),
    .s_av_error         (s_err),
    .s_av_ready         (s_ready),
    .m_av_data          (m_data),
    .m_av_empty         (m_empty),
    .m_av_valid         (m_valid),
    .m_av_startofpacket (m_sop),
    .m_av_endofpacket   (m_eop),
    .m_av_error         (m_err),
    .m_av_channel       (m_ch),
    .m_av_ready         (m_ready),
    .pkt_cnt            (pkt_cnt),
    .sop_err            (sop_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus state
  av_beat_t src_q[NP][$];
  av_beat_t exp_q[NP][$];
  int rdy_mode = 0;
  int gap_pct  = 0;
  int cyc      = 0;
  int stall_at[NP], stall_left[NP], sent_cnt[NP];

  // reference model state
  int          last_served;
  int          cur;
  bit          arb_idle, first_pend, out_in_pkt;
  int          out_ch;
  logic [31:0] pkt_model;
  int          sop_pulses;
  logic [EW-1:0] last_m_empty;
  int          sop_list[$];

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [639:0] pk(input av_beat_t b);
    logic [639:0] r;
    r = '0;
    r[$bits(av_beat_t)-1:0] = b;
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // next requester strictly after 'from', wrapping
  function automatic int rr_pick(input logic [NP-1:0] v, input int from);
    for (int off = 1; off <= NP; off++)
      if (v[(from + off) % NP]) return (from + off) % NP;
    return -1;
  endfunction

  task automatic gen_pkt(input int p, input int n, input bit sop_ok, input logic [EW-1:0] last_empty);
    av_beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = rnd_data();
      b.sop   = (i == 0) && sop_ok;
      b.eop   = (i == n - 1);
      b.empty = b.eop ? last_empty : '0;
      b.error = b.eop ? 1'($urandom_range(1)) : 1'b0;
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      stall_at[p] = 0; stall_left[p] = 0; sent_cnt[p] = 0;
    end
    last_served = NP - 1;
    cur = 0;
    arb_idle = 1; first_pend = 0; out_in_pkt = 0; out_ch = 0;
    pkt_model = '0;
  endtask

  // One clock: drive after negedge, check before/after posedge, return at next negedge.
  task automatic tick();
    logic [NP-1:0] acc, exp_rdy;
    logic v, load;
    bit exp_se;
    int ch;
    av_beat_t b, mb;
    for (int p = 0; p < NP; p++) begin
      v = 1'b0;
      if (src_q[p].size() > 0) begin
        if (stall_left[p] > 0 && sent_cnt[p] == stall_at[p]) stall_left[p]--;
        else v = ($urandom_range(99) >= gap_pct);
        s_data[p]  = src_q[p][0].data;
        s_empty[p] = src_q[p][0].empty;
        s_sop[p]   = src_q[p][0].sop;
        s_eop[p]   = src_q[p][0].eop;
        s_err[p]   = src_q[p][0].error;
      end
      s_valid[p] = v;
    end
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 2 == 0);
      default: m_ready = ($urandom_range(3) != 0);
    endcase
    cyc++;
    #1;
    load    = !m_valid || m_ready;
    exp_rdy = '0;
    if (!arb_idle) exp_rdy[cur] = load;
    chk("s_ready", s_ready, exp_rdy);
    acc    = s_valid & s_ready;
    exp_se = 0;
    if (arb_idle) begin
      if (|s_valid) begin
        cur = rr_pick(s_valid, last_served);
        arb_idle = 0;
        first_pend = 1;
      end
    end else if (acc[cur]) begin
      b = src_q[cur][0];
      exp_se = first_pend && !b.sop;
      first_pend = 0;
      if (b.eop) begin
        arb_idle = 1;
        last_served = cur;
      end
    end
    if (m_valid && m_ready) begin
      ch = int'(m_ch);
      mb.data = m_data; mb.empty = m_empty; mb.sop = m_sop; mb.eop = m_eop; mb.error = m_err;
      last_m_empty = m_empty;
      if (exp_q[ch].size() == 0) chk("m_unexpected_beat", exp_q[ch].size(), 1);
      else chk("m_beat", pk(mb), pk(exp_q[ch].pop_front()));
      if (out_in_pkt) chk("m_interleave", ch, out_ch);
      else begin
        out_ch = ch;
        sop_list.push_back(ch);
      end
      out_in_pkt = !mb.eop;
      if (mb.eop) pkt_model++;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      if (acc[p] && src_q[p].size() > 0) begin
        void'(src_q[p].pop_front());
        sent_cnt[p]++;
      end
    chk("sop_err", sop_err, exp_se);
    chk("pkt_cnt", pkt_cnt, pkt_model);
    if (sop_err) sop_pulses++;
    @(negedge clk);
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++)
      if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (!all_empty() && c < maxc) begin
      tick();
      c++;
    end
    chk("drain_timeout", (c < maxc), 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_pulses, base_pkts, g;
    s_data = '0; s_empty = '0; s_sop = '0; s_eop = '0; s_err = '0;
    m_ready = 1'b1;

    // 1: reset held with all sources requesting
    s_valid = '1;
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_s_ready", s_ready, 2'b00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    chk("rst_sop_err", sop_err, 1'b0);
    chk("rst_m_ch", m_ch, 1'b0);
    s_valid = '0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // 2: continuous 2-beat packets on both ports
    rdy_mode = 0; gap_pct = 0;
    sop_list.delete();
    for (int k = 0; k < 3; k++) begin
      gen_pkt(0, 2, 1, EW'($urandom_range(63)));
      gen_pkt(1, 2, 1, EW'($urandom_range(63)));
    end
    drain(200);
    chk("rr_count", sop_list.size(), 6);
    for (int i = 0; i < 6 && i < sop_list.size(); i++) chk("rr_order", sop_list[i], i % 2);
    chk("pkt_cnt_6", pkt_cnt, 32'd6);

    // 3: 5-beat packet under alternating sink backpressure
    rdy_mode = 1;
    gen_pkt(1, 5, 1, EW'(7));
    drain(200);
    chk("bp_pkt_cnt", pkt_cnt, 32'd7);

    // 4: port 0 pauses mid-packet while port 1 waits
    rdy_mode = 0;
    sop_list.delete();
    for (int p = 0; p < NP; p++) sent_cnt[p] = 0;
    gen_pkt(0, 4, 1, EW'(1));
    gen_pkt(1, 2, 1, EW'(2));
    stall_at[0] = 2; stall_left[0] = 3;
    drain(200);
    chk("gap_count", sop_list.size(), 2);
    if (sop_list.size() == 2) begin
      chk("gap_first", sop_list[0], 0);
      chk("gap_second", sop_list[1], 1);
    end

    // 5: missing SOP, then single-beat packet
    base_pulses = sop_pulses;
    base_pkts   = int'(pkt_cnt);
    gen_pkt(0, 2, 0, EW'(5));
    gen_pkt(0, 1, 1, EW'(8'h3C));
    drain(200);
    chk("sop_err_pulses", sop_pulses - base_pulses, 1);
    chk("single_empty", last_m_empty, EW'(8'h3C));
    chk("single_pkts", int'(pkt_cnt) - base_pkts, 2);

    // randomized traffic
    rdy_mode = 2; gap_pct = 25;
    for (int k = 0; k < 30; k++)
      gen_pkt($urandom_range(NP - 1), $urandom_range(1, 6), ($urandom_range(7) != 0),
              EW'($urandom_range(63)));
    drain(4000);

    // 6: asynchronous reset in the middle of a 4-beat packet
    rdy_mode = 0; gap_pct = 0;
    gen_pkt(0, 4, 1, EW'(3));
    g = 0;
    while (src_q[0].size() > 2 && g < 50) begin
      tick();
      g++;
    end
    chk("pre_rst_m_valid", m_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_s_ready", s_ready, 2'b00);
    chk("arst_pkt_cnt", pkt_cnt, 32'd0);
    s_valid = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sop_list.delete();
    gen_pkt(1, 3, 1, EW'(4));
    gen_pkt(0, 3, 1, EW'(6));
    drain(200);
    chk("post_rst_count", sop_list.size(), 2);
    if (sop_list.size() == 2) begin
      chk("post_rst_first", sop_list[0], 0);
      chk("post_rst_second", sop_list[1], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
